// File: rtl/timing_loop_pkg.sv
// Shared types and arithmetic helpers for the symbol-timing recovery loop.
// Saturation helpers work on 32-bit signed values so any loop width up to 31 bits can use them.
package timing_loop_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NCO_WIDTH  = 16;
  localparam int DEF_MU_WIDTH   = 16;
  localparam int DEF_LOCK_CNT   = 16;
  localparam int DEF_UNLOCK_CNT = 8;

  typedef enum logic [1:0] {
    ACQ   = 2'b00,
    TRACK = 2'b01
  } loop_state_t;

  function automatic logic signed [31:0] SAT_V(input logic signed [31:0] x,
                                               input logic signed [31:0] lim);
    if (x > lim) begin
      return lim;
    end else if (x < -lim) begin
      return -lim;
    end else begin
      return x;
    end
  endfunction

  // Magnitude of a sign-extended sample, clamped so the most-negative code fits width-1 bits.
  function automatic logic [31:0] ABS_SAT(input logic signed [31:0] x, input int width);
    logic signed [31:0] mag;
    logic signed [31:0] max_mag;
    max_mag = (32'sd1 <<< (width - 1)) - 32'sd1;
    mag     = (x < 0) ? -x : x;
    if (mag > max_mag) begin
      mag = max_mag;
    end
    return 32'(mag);
  endfunction

endpackage

// File: rtl/timing_loop_ctrl_if.sv
// Sample/error/strobe bundle between the timing loop controller and its datapath neighbours.
interface timing_loop_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int MU_WIDTH   = 16
);

  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] e_k_zs;
  logic                         zs_valid;
  logic                         underflow;
  logic [MU_WIDTH-1:0]          mu;
  logic signed [DATA_WIDTH-1:0] v_out;
  logic                         locked;
  logic [1:0]                   state;

  modport master (
    output in_valid,
    output e_k_zs,
    output zs_valid,
    input  underflow,
    input  mu,
    input  v_out,
    input  locked,
    input  state
  );

  modport slave (
    input  in_valid,
    input  e_k_zs,
    input  zs_valid,
    output underflow,
    output mu,
    output v_out,
    output locked,
    output state
  );

endinterface

// File: rtl/timing_loop_pi_filter.sv
// Proportional-integral loop filter: shift-scaled error, saturating integrator, clamped v_out register.
module timing_loop_pi_filter
  import timing_loop_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int V_MAX      = 2 ** (DATA_WIDTH - 4)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         zs_valid,
  input  logic                         freeze,
  input  logic                         gain_sel,
  input  logic signed [DATA_WIDTH-1:0] e_k_zs,
  input  logic [3:0]                   kp_shift_acq,
  input  logic [3:0]                   ki_shift_acq,
  input  logic [3:0]                   kp_shift_trk,
  input  logic [3:0]                   ki_shift_trk,
  output logic signed [DATA_WIDTH-1:0] v_out
);

  localparam int IW = DATA_WIDTH + 4;
  localparam logic signed [31:0] INTEG_LIM = (32'sd1 <<< (IW - 1)) - 32'sd1;
  localparam logic signed [31:0] V_LIM     = 32'(V_MAX);

  logic signed [IW-1:0]         integ;
  logic [3:0]                   kp;
  logic [3:0]                   ki;
  logic signed [DATA_WIDTH-1:0] p_term;
  logic signed [DATA_WIDTH-1:0] i_inc;
  logic signed [31:0]           integ_next;
  logic signed [31:0]           v_next;

  // v uses the integrator value that already includes the current sample.
  always_comb begin
    kp         = gain_sel ? kp_shift_trk : kp_shift_acq;
    ki         = gain_sel ? ki_shift_trk : ki_shift_acq;
    p_term     = e_k_zs >>> kp;
    i_inc      = e_k_zs >>> ki;
    integ_next = SAT_V(32'(integ) + 32'(i_inc), INTEG_LIM);
    v_next     = SAT_V(32'(p_term) + integ_next, V_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ <= '0;
      v_out <= '0;
    end else if (clear) begin
      integ <= '0;
      v_out <= '0;
    end else if (zs_valid && !freeze) begin
      integ <= integ_next[IW-1:0];
      v_out <= v_next[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/timing_loop_ctrl.sv
// Symbol-timing loop controller: mod-1 NCO, PI filter and ACQ/TRACK gain scheduling.
// Optional TIMING_LOOP_FREEZE_EN adds a freeze input that holds the filter and lock FSM.
module timing_loop_ctrl
  import timing_loop_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NCO_WIDTH  = DEF_NCO_WIDTH,
  parameter int MU_WIDTH   = DEF_MU_WIDTH,
  parameter int W_NOM      = 2 ** (NCO_WIDTH - 1),
  parameter int V_MAX      = 2 ** (DATA_WIDTH - 4),
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int UNLOCK_CNT = DEF_UNLOCK_CNT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [3:0]            kp_shift_acq,
  input  logic [3:0]            ki_shift_acq,
  input  logic [3:0]            kp_shift_trk,
  input  logic [3:0]            ki_shift_trk,
  input  logic [DATA_WIDTH-2:0] lock_thresh,
`ifdef TIMING_LOOP_FREEZE_EN
  input  logic                  freeze,
`endif
  timing_loop_ctrl_if.slave     bus
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam int SW = NCO_WIDTH + 2;

  logic                         freeze_i;
  logic signed [DATA_WIDTH-1:0] v_q;
  logic [NCO_WIDTH-1:0]         nco;
  logic signed [SW-1:0]         step;
  logic signed [SW-1:0]         diff;
  logic                         borrow;
  logic [NCO_WIDTH-1:0]         eta2;
  logic [MU_WIDTH-1:0]          mu_next;
  logic                         underflow_q;
  logic [MU_WIDTH-1:0]          mu_q;
  loop_state_t                  st;
  logic                         locked_q;
  logic [GW-1:0]                good_cnt;
  logic [BW-1:0]                bad_cnt;
  logic                         in_thresh;

`ifdef TIMING_LOOP_FREEZE_EN
  assign freeze_i = freeze;
`else
  assign freeze_i = 1'b0;
`endif

  timing_loop_pi_filter #(
    .DATA_WIDTH (DATA_WIDTH),
    .V_MAX      (V_MAX)
  ) u_pi_filter (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (!enable),
    .zs_valid     (bus.zs_valid),
    .freeze       (freeze_i),
    .gain_sel     (st == TRACK),
    .e_k_zs       (bus.e_k_zs),
    .kp_shift_acq (kp_shift_acq),
    .ki_shift_acq (ki_shift_acq),
    .kp_shift_trk (kp_shift_trk),
    .ki_shift_trk (ki_shift_trk),
    .v_out        (v_q)
  );

  // The step is widened past NCO_WIDTH so the sign of the difference is the borrow.
  always_comb begin
    step    = SW'(W_NOM) + SW'(v_q);
    diff    = signed'({2'b00, nco}) - step;
    borrow  = diff[SW-1];
    eta2    = {nco[NCO_WIDTH-2:0], 1'b0};
    mu_next = eta2[NCO_WIDTH-1 -: MU_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nco         <= '1;
      underflow_q <= 1'b0;
      mu_q        <= '0;
    end else if (!enable) begin
      nco         <= '1;
      underflow_q <= 1'b0;
      mu_q        <= '0;
    end else if (bus.in_valid) begin
      nco         <= diff[NCO_WIDTH-1:0];
      underflow_q <= borrow;
      if (borrow) begin
        mu_q <= mu_next;
      end
    end else begin
      underflow_q <= 1'b0;
    end
  end

  assign in_thresh = ABS_SAT(32'(bus.e_k_zs), DATA_WIDTH) <= 32'(lock_thresh);

  // Lock hysteresis; the filter sees the new gain set only from the following zs_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ACQ;
      locked_q <= 1'b0;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (!enable) begin
      st       <= ACQ;
      locked_q <= 1'b0;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (bus.zs_valid && !freeze_i) begin
      case (st)
        ACQ: begin
          if (in_thresh) begin
            if (good_cnt == GW'(LOCK_CNT - 1)) begin
              st       <= TRACK;
              locked_q <= 1'b1;
              good_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end else begin
            good_cnt <= '0;
          end
        end
        TRACK: begin
          if (!in_thresh) begin
            if (bad_cnt == BW'(UNLOCK_CNT - 1)) begin
              st       <= ACQ;
              locked_q <= 1'b0;
              bad_cnt  <= '0;
            end else begin
              bad_cnt <= bad_cnt + 1'b1;
            end
          end else begin
            bad_cnt <= '0;
          end
        end
        default: begin
          st       <= ACQ;
          locked_q <= 1'b0;
          good_cnt <= '0;
          bad_cnt  <= '0;
        end
      endcase
    end
  end

  assign bus.underflow = underflow_q;
  assign bus.mu        = mu_q;
  assign bus.v_out     = v_q;
  assign bus.locked    = locked_q;
  assign bus.state     = st;

endmodule

// File: tb/tb_timing_loop_ctrl.sv
// Self-checking bench for timing_loop_ctrl against an arithmetic model of the loop.
module tb_timing_loop_ctrl;

  localparam int DW         = 16;
  localparam int MW         = 16;
  localparam int NCO_MOD    = 65536;
  localparam int W_NOM      = 32768;
  localparam int V_MAX      = 4096;
  localparam int LOCK_CNT   = 16;
  localparam int UNLOCK_CNT = 8;
  localparam int INTEG_MAX  = (1 << 19) - 1;
`ifdef TIMING_LOOP_FREEZE_EN
  localparam bit HAS_FREEZE = 1'b1;
`else
  localparam bit HAS_FREEZE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic          freeze = 1'b0;
  logic [3:0]    kp_acq, ki_acq, kp_trk, ki_trk;
  logic [DW-2:0] lock_thresh;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_nco, m_integ, m_v, m_mu, m_state, m_good, m_bad;
  bit m_under;

  timing_loop_ctrl_if #(.DATA_WIDTH(DW), .MU_WIDTH(MW)) bus ();

  timing_loop_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .kp_shift_acq (kp_acq),
    .ki_shift_acq (ki_acq),
    .kp_shift_trk (kp_trk),
    .ki_shift_trk (ki_trk),
    .lock_thresh  (lock_thresh),
`ifdef TIMING_LOOP_FREEZE_EN
    .freeze       (freeze),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  function automatic int clampi(input int x, input int lim);
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

  task automatic model_clear();
    m_nco   = NCO_MOD - 1;
    m_integ = 0;
    m_v     = 0;
    m_mu    = 0;
    m_under = 1'b0;
    m_state = 0;
    m_good  = 0;
    m_bad   = 0;
  endtask

  // One clock of stimulus; the model advances to the post-edge values, then returns 1 time unit after the edge.
  task automatic drive_cycle(input bit iv, input bit zv, input int e, input bit en);
    int old_v, old_state, step, kp, ki, mag;
    bus.in_valid = iv;
    bus.zs_valid = zv;
    bus.e_k_zs   = 16'(e);
    enable       = en;
    @(posedge clk);
    if (!en) begin
      model_clear();
    end else begin
      old_v     = m_v;
      old_state = m_state;
      m_under   = 1'b0;
      if (iv) begin
        step = W_NOM + old_v;
        if (m_nco < step) begin
          m_under = 1'b1;
          m_mu    = (m_nco * 2) % NCO_MOD;
        end
        m_nco = (m_nco - step + 2 * NCO_MOD) % NCO_MOD;
      end
      if (zv && !(HAS_FREEZE && freeze)) begin
        kp      = (old_state == 1) ? int'(kp_trk) : int'(kp_acq);
        ki      = (old_state == 1) ? int'(ki_trk) : int'(ki_acq);
        m_integ = clampi(m_integ + (e >>> ki), INTEG_MAX);
        m_v     = clampi((e >>> kp) + m_integ, V_MAX);
        mag     = (e < 0) ? -e : e;
        if (mag > 32767) mag = 32767;
        if (old_state == 0) begin
          if (mag <= int'(lock_thresh)) begin
            m_good++;
            if (m_good == LOCK_CNT) begin
              m_state = 1;
              m_good  = 0;
            end
          end else begin
            m_good = 0;
          end
        end else begin
          if (mag > int'(lock_thresh)) begin
            m_bad++;
            if (m_bad == UNLOCK_CNT) begin
              m_state = 0;
              m_bad   = 0;
            end
          end else begin
            m_bad = 0;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    kp_acq = 4'd3; ki_acq = 4'd6; kp_trk = 4'd5; ki_trk = 4'd8;
    lock_thresh = 15'd100;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b1, 1'b1, int'($urandom_range(0, 600)) - 300, 1'b1);
    end
    bus.in_valid = 1'b0;
    bus.zs_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.underflow !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_underflow got=%0b exp=0", bus.underflow);
    end
    checks++;
    if (bus.v_out !== 16'sd0) begin
      errors++; $display("[TB] FAIL reset_v_out got=%0d exp=0", bus.v_out);
    end
    checks++;
    if (bus.state !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_state got=%b exp=00", bus.state);
    end
    checks++;
    if (bus.locked !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_locked got=%0b exp=0", bus.locked);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b1, 1'b0, 0, 1'b1);
    checks++;
    if (bus.underflow !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_first_step underflow got=%0b exp=0", bus.underflow);
    end
    drive_cycle(1'b1, 1'b0, 0, 1'b1);
    checks++;
    if (bus.underflow !== 1'b1 || bus.mu !== 16'hFFFE) begin
      errors++; $display("[TB] FAIL reset_second_step underflow=%0b mu=%h exp 1/fffe", bus.underflow, bus.mu);
    end
  endtask

  task automatic test_nominal();
    drive_cycle(1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 1'b0, 0, 1'b1);
      checks++;
      if (bus.underflow !== 1'((i % 2) == 1)) begin
        errors++; $display("[TB] FAIL nominal_underflow beat=%0d got=%0b exp=%0b", i + 1, bus.underflow, (i % 2) == 1);
      end
      if (bus.underflow === 1'b1) begin
        checks++;
        if (bus.mu !== 16'hFFFE) begin
          errors++; $display("[TB] FAIL nominal_mu beat=%0d got=%h exp=fffe", i + 1, bus.mu);
        end
      end
    end
  endtask

  task automatic test_gaps();
    bit pattern [14] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
    int beats;
    bit exp_u;
    drive_cycle(1'b0, 1'b0, 0, 1'b0);
    beats = 0;
    for (int i = 0; i < 14; i++) begin
      drive_cycle(pattern[i], 1'b0, 0, 1'b1);
      if (pattern[i]) beats++;
      exp_u = pattern[i] && (beats % 2 == 0);
      checks++;
      if (bus.underflow !== exp_u || bus.mu !== 16'(m_mu)) begin
        errors++; $display("[TB] FAIL gaps cyc=%0d underflow=%0b mu=%h exp %0b/%h", i, bus.underflow, bus.mu, exp_u, 16'(m_mu));
      end
    end
  endtask

  task automatic test_lock_hysteresis();
    kp_acq = 4'd15; ki_acq = 4'd15; kp_trk = 4'd15; ki_trk = 4'd15;
    lock_thresh = 15'd100;
    drive_cycle(1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b0, 1'b1, 50, 1'b1);
      checks++;
      if (bus.locked !== 1'(i == 15) || bus.state !== ((i == 15) ? 2'b01 : 2'b00)) begin
        errors++; $display("[TB] FAIL lock_entry n=%0d locked=%0b state=%b exp_locked=%0b", i + 1, bus.locked, bus.state, i == 15);
      end
    end
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b0, 1'b1, (i == 7) ? 0 : 500, 1'b1);
      checks++;
      if (bus.locked !== 1'(i != 15) || bus.state !== ((i != 15) ? 2'b01 : 2'b00)) begin
        errors++; $display("[TB] FAIL lock_hysteresis n=%0d locked=%0b state=%b exp_locked=%0b", i + 1, bus.locked, bus.state, i != 15);
      end
    end
  endtask

  task automatic test_saturation();
    kp_acq = 4'd0; ki_acq = 4'd0; kp_trk = 4'd0; ki_trk = 4'd0;
    lock_thresh = 15'd100;
    drive_cycle(1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 1'b1, 32767, 1'b1);
      checks++;
      if (bus.v_out !== 16'sd4096) begin
        errors++; $display("[TB] FAIL sat_pos n=%0d v_out=%0d exp=4096", i, bus.v_out);
      end
    end
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 1'b0, 0, 1'b1);
      checks++;
      if (bus.underflow !== m_under || bus.mu !== 16'(m_mu)) begin
        errors++; $display("[TB] FAIL sat_step n=%0d underflow=%0b mu=%h exp %0b/%h", i, bus.underflow, bus.mu, m_under, 16'(m_mu));
      end
    end
    for (int i = 0; i < 24; i++) begin
      drive_cycle(1'b1, 1'b1, -32768, 1'b1);
      checks++;
      if (bus.v_out !== 16'(m_v) || bus.underflow !== m_under) begin
        errors++; $display("[TB] FAIL sat_neg_track n=%0d v_out=%0d underflow=%0b exp %0d/%0b", i, bus.v_out, bus.underflow, m_v, m_under);
      end
    end
    checks++;
    if (bus.v_out !== -16'sd4096) begin
      errors++; $display("[TB] FAIL sat_neg v_out=%0d exp=-4096", bus.v_out);
    end
  endtask

  task automatic test_gain_switch();
    kp_acq = 4'd2; ki_acq = 4'd15; kp_trk = 4'd6; ki_trk = 4'd15;
    lock_thresh = 15'd100;
    drive_cycle(1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      drive_cycle(1'b0, 1'b1, 0, 1'b1);
    end
    drive_cycle(1'b0, 1'b1, 64, 1'b1);
    checks++;
    if (bus.v_out !== 16'sd16 || bus.locked !== 1'b1) begin
      errors++; $display("[TB] FAIL gain_switch_last_acq v_out=%0d locked=%0b exp 16/1", bus.v_out, bus.locked);
    end
    drive_cycle(1'b0, 1'b1, 64, 1'b1);
    checks++;
    if (bus.v_out !== 16'sd1) begin
      errors++; $display("[TB] FAIL gain_switch_first_trk v_out=%0d exp=1", bus.v_out);
    end
`ifdef TIMING_LOOP_FREEZE_EN
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 1'b1, -1000, 1'b1);
      checks++;
      if (bus.v_out !== 16'sd1 || bus.locked !== 1'b1 || bus.underflow !== m_under) begin
        errors++; $display("[TB] FAIL freeze_hold n=%0d v_out=%0d locked=%0b underflow=%0b exp 1/1/%0b", i, bus.v_out, bus.locked, bus.underflow, m_under);
      end
    end
    freeze = 1'b0;
`endif
  endtask

  task automatic test_random();
    logic [35:0] got, exp;
    bit iv, zv, en;
    int e;
    lock_thresh = 15'd150;
    for (int i = 0; i < 2000; i++) begin
      if (i % 128 == 0) begin
        kp_acq = 4'($urandom_range(0, 15)); ki_acq = 4'($urandom_range(0, 15));
        kp_trk = 4'($urandom_range(0, 15)); ki_trk = 4'($urandom_range(0, 15));
      end
      en = ($urandom_range(0, 99) != 0);
      iv = ($urandom_range(0, 3) != 0);
      zv = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) e = int'($urandom_range(0, 65535)) - 32768;
      else e = int'($urandom_range(0, 400)) - 200;
`ifdef TIMING_LOOP_FREEZE_EN
      freeze = ($urandom_range(0, 7) == 0);
`endif
      drive_cycle(iv, zv, e, en);
      exp = {m_under, 16'(m_mu), 16'(m_v), 2'(m_state), 1'(m_state == 1)};
      got = {bus.underflow, bus.mu, bus.v_out, bus.state, bus.locked};
      checks++;
      if (got !== exp) begin
        errors++; $display("[TB] FAIL random cyc=%0d got=%h exp=%h (underflow,mu,v_out,state,locked)", i, got, exp);
      end
    end
    freeze = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.zs_valid = 1'b0;
    bus.e_k_zs   = '0;
    kp_acq = 4'd0; ki_acq = 4'd0; kp_trk = 4'd0; ki_trk = 4'd0;
    lock_thresh = 15'd100;
    model_clear();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("[TB] starting timing_loop_ctrl bench");
    test_reset();
    test_nominal();
    test_gaps();
    test_lock_hysteresis();
    test_saturation();
    test_gain_switch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timing_loop_ctrl.md
Name: timing_loop_ctrl

Overview:
Symbol-timing recovery loop controller. It owns the mod-1 NCO and the PI loop filter, and schedules acquisition versus tracking gains. It emits the NCO underflow strobe that sequences the ZCTED and the zero-stuffer, and it consumes their zero-stuffed timing error (e_k_zs, zs_valid). It also emits the fractional interval mu to the interpolator and a lock indication to downstream framing.

Parameters:
DATA_WIDTH, 16, width of signed timing error and loop-filter output v
NCO_WIDTH, 16, unsigned NCO register width
MU_WIDTH, 16, unsigned fractional interval width (MU_WIDTH <= NCO_WIDTH)
W_NOM, 2**(NCO_WIDTH-1), nominal NCO step (2 samples/symbol)
V_MAX, 2**(DATA_WIDTH-4), symmetric saturation bound on v
LOCK_CNT, 16, consecutive in-threshold errors needed to enter TRACK
UNLOCK_CNT, 8, consecutive out-of-threshold errors needed to drop to ACQ

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  loop run; low = synchronous soft clear
in_valid  in  1  one input sample available this cycle
e_k_zs  in  DATA_WIDTH  signed zero-stuffed timing error
zs_valid  in  1  e_k_zs holds a real error sample
kp_shift_acq / ki_shift_acq  in  4 each  proportional / integral right-shift used in ACQ
kp_shift_trk / ki_shift_trk  in  4 each  proportional / integral right-shift used in TRACK
lock_thresh  in  DATA_WIDTH-1  unsigned |e| threshold
underflow  out  1  registered NCO underflow strobe (symbol strobe)
mu  out  MU_WIDTH  fractional interval, valid with underflow, held otherwise
v_out  out  DATA_WIDTH  signed loop-filter output
locked  out  1  high in TRACK
state  out  2  00 ACQ, 01 TRACK

Behaviour:
- Reset (rst_n low, async): nco = all-ones, integ = 0, v_out = 0, underflow = 0, mu = 0, locked = 0, state = ACQ, counters = 0.
- enable low: same values as reset, applied synchronously; in_valid and zs_valid are ignored.
- NCO: on in_valid, step = W_NOM + v_out (signed add, NCO_WIDTH+1 bits). nco_next = (nco - step) mod 2^NCO_WIDTH.
- Borrow (nco < step) sets underflow high for exactly one cycle, the cycle after that in_valid. In the same edge, mu is loaded with {nco[NCO_WIDTH-2:0],1'b0} truncated to its MSB MU_WIDTH bits, i.e. 2*eta using the pre-decrement value.
- No in_valid: nco holds, underflow = 0.
- Loop filter: updates only on zs_valid; e_k_zs is ignored otherwise.
  - p = e >>> kp, i_inc = e >>> ki; shifts are arithmetic and taken from the gain set of the current state.
  - integ is DATA_WIDTH+4 bits, saturating; v = sat(p + integ, ±V_MAX).
  - v_out is registered and used by the NCO from the next cycle, so there is 1-cycle latency from zs_valid to v_out.
- Lock FSM (evaluated on zs_valid only):
  - ACQ: |e| <= lock_thresh increments good_cnt, otherwise good_cnt = 0. When good_cnt reaches LOCK_CNT: go to TRACK, good_cnt = 0.
  - TRACK: |e| > lock_thresh increments bad_cnt, otherwise bad_cnt = 0. When bad_cnt reaches UNLOCK_CNT: go to ACQ, bad_cnt = 0.
  - |e| of the most-negative value saturates to 2^(DATA_WIDTH-1)-1.
  - A state change takes effect at the edge after the qualifying zs_valid. The gain set switches for the next zs_valid, never for the sample that caused the transition. The integrator is not cleared on transition.
- Simultaneous in_valid and zs_valid: the NCO uses the old v_out and the filter updates v_out; both happen in the same edge.

Optional Feature:
TIMING_LOOP_FREEZE_EN: adds input port freeze (1 bit). While freeze is high:
- integ, v_out, the lock counters and state hold;
- the NCO keeps stepping with the held v_out.
Without the macro the port does not exist and the loop always updates on zs_valid.

Decomposition:
- Package timing_loop_pkg: state enum (ACQ, TRACK), the SAT_V saturation function, the ABS_SAT function and default widths.
- One sub-module, timing_loop_pi_filter, holds the shift/add/saturate integrator and v_out register. It has gain-select, zs_valid and freeze inputs.
- NCO and FSM stay in the top.

Test Plan:
- Reset and defaults: assert rst_n=0 mid-run -> immediately underflow=0, v_out=0, state=00, locked=0; first in_valid after release takes nco 0xFFFF->0x7FFF with no underflow.
- Nominal step: v=0, e=0, in_valid every cycle -> underflow on every 2nd in_valid, first at the 2nd; mu=0xFFFE.
- Sample gaps: in_valid with a 3-cycle gap inserted -> no underflow in the gap, nco held; underflow cadence resumes counted in in_valid beats.
- Lock and hysteresis: lock_thresh=100, e=50 for 16 zs_valid -> locked=1 one cycle after the 16th.
  - Then e=500 x7, e=0 x1, e=500 x8 -> stays TRACK through the 7; returns to ACQ one cycle after the final 8th.
- Saturation: e=+32767 on every zs_valid, kp=ki=0 -> v_out clamps at +4096 and NCO step = 0x9000; e=-32768 -> v_out = -4096.
- Gain switch timing: in ACQ with kp_acq=2, kp_trk=6, integ preloaded to 0 via enable toggle, the 16th locking sample e=64 -> its contribution uses >>>2. The next sample uses >>>6 (with the feature enabled, freeze=1 holds v_out constant).
